// File: rtl/alu_writeback_stage_if.sv
// Bundle between the ALU/issue side and the execute/writeback stage:
// ALU result bundle in, register-file write port and flag feedback out.
interface alu_writeback_stage_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_result;
  logic [3:0]         in_new_flag;
  logic [3:0]         in_opcode;
  logic [3:0]         in_cond;
  logic               in_s;
  logic [RADDR_W-1:0] in_rd;
  logic               wb_stall;
  logic [3:0]         flag_out;
  logic               flags_pending;
  logic               wb_en;
  logic [RADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]  wb_data;
  logic               commit_pulse;
  logic               squash_pulse;

  modport master (
    output in_valid, in_result, in_new_flag, in_opcode, in_cond, in_s, in_rd, wb_stall,
    input  in_ready, flag_out, flags_pending, wb_en, wb_addr, wb_data,
           commit_pulse, squash_pulse
  );

  modport slave (
    input  in_valid, in_result, in_new_flag, in_opcode, in_cond, in_s, in_rd, wb_stall,
    output in_ready, flag_out, flags_pending, wb_en, wb_addr, wb_data,
           commit_pulse, squash_pulse
  );
endinterface

// File: rtl/alu_writeback_stage.sv
// Execute/writeback stage: buffers ALU bundles, evaluates Cond against NZCV,
// commits passing results to the register file and updates the flags.
module alu_writeback_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4,
  parameter int DEPTH   = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  alu_writeback_stage_if.slave io
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  typedef struct packed {
    logic [DATA_W-1:0]  result;
    logic [3:0]         newFlag;
    logic [3:0]         opcode;
    logic [3:0]         cond;
    logic               s;
    logic [RADDR_W-1:0] rd;
  } entry_t;

  // Flags are {N,Z,C,V}.
  function automatic logic condPass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: condPass = z;
      4'h1: condPass = !z;
      4'h2: condPass = c;
      4'h3: condPass = !c;
      4'h4: condPass = n;
      4'h5: condPass = !n;
      4'h6: condPass = v;
      4'h7: condPass = !v;
      4'h8: condPass = c && !z;
      4'h9: condPass = !c || z;
      4'hA: condPass = (n == v);
      4'hB: condPass = (n != v);
      4'hC: condPass = !z && (n == v);
      4'hD: condPass = z || (n != v);
      4'hE: condPass = 1'b1;
      4'hF: condPass = 1'b0;
    endcase
  endfunction

  // CMP always sets flags; MOVs and non-ALU opcodes never do.
  function automatic logic setsFlags(input logic [3:0] op, input logic s);
    setsFlags = (op == 4'hB) ||
                (s && ((op <= 4'h5) || ((op >= 4'h8) && (op <= 4'hA))));
  endfunction

  entry_t             mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [3:0]         flag_q, flag_d;
  logic               wbEn_q, wbEn_d;
  logic [RADDR_W-1:0] wbAddr_q, wbAddr_d;
  logic [DATA_W-1:0]  wbData_q, wbData_d;
  logic               commit_q, commit_d;
  logic               squash_q, squash_d;

  logic [PTR_W-1:0]   wrSlot, rdSlot;
  logic               full, empty, push, pop;
  logic               headPass, headAlu, headWrites;
  logic               pendingAny;
  entry_t             head, incoming;

  assign wrSlot   = wrPtr_q[PTR_W-1:0];
  assign rdSlot   = rdPtr_q[PTR_W-1:0];
  assign empty    = (wrPtr_q == rdPtr_q);
  assign full     = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) && (wrSlot == rdSlot);
  assign push     = io.in_valid && !full;
  assign pop      = !empty && !io.wb_stall;
  assign head     = mem_q[rdSlot];
  assign incoming = '{result: io.in_result, newFlag: io.in_new_flag, opcode: io.in_opcode,
                      cond: io.in_cond, s: io.in_s, rd: io.in_rd};

  assign headPass   = condPass(head.cond, flag_q);
  assign headAlu    = (head.opcode <= 4'hB);
  assign headWrites = headPass && (head.opcode <= 4'hA);

  always_comb begin
    pendingAny = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && setsFlags(mem_q[i].opcode, mem_q[i].s)) pendingAny = 1'b1;
    end
  end

  always_comb begin
    valid_d  = valid_q;
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    flag_d   = flag_q;
    wbEn_d   = 1'b0;
    wbAddr_d = wbAddr_q;
    wbData_d = wbData_q;
    commit_d = 1'b0;
    squash_d = 1'b0;
    if (pop) begin
      valid_d[rdSlot] = 1'b0;
      rdPtr_d         = rdPtr_q + PTR_ONE;
      commit_d        = headPass && headAlu;
      squash_d        = !(headPass && headAlu);
      if (headWrites) begin
        wbEn_d   = 1'b1;
        wbAddr_d = head.rd;
        wbData_d = head.result;
      end
      if (headPass && setsFlags(head.opcode, head.s)) flag_d = head.newFlag;
    end
    if (push) begin
      valid_d[wrSlot] = 1'b1;
      wrPtr_d         = wrPtr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      flag_q   <= 4'b0000;
      wbEn_q   <= 1'b0;
      wbAddr_q <= '0;
      wbData_q <= '0;
      commit_q <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      flag_q   <= flag_d;
      wbEn_q   <= wbEn_d;
      wbAddr_q <= wbAddr_d;
      wbData_q <= wbData_d;
      commit_q <= commit_d;
      squash_q <= squash_d;
    end
  end

  // Payload storage needs no reset; valid_q and the pointers qualify it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrSlot] <= incoming;
  end

  assign io.in_ready      = !full;
  assign io.flags_pending = pendingAny;
  assign io.flag_out      = flag_q;
  assign io.wb_en         = wbEn_q;
  assign io.wb_addr       = wbAddr_q;
  assign io.wb_data       = wbData_q;
  assign io.commit_pulse  = commit_q;
  assign io.squash_pulse  = squash_q;
endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_alu_writeback_stage;
  localparam int DATA_W  = 32;
  localparam int RADDR_W = 4;
  localparam int DEPTH   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_writeback_stage_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) io ();

  alu_writeback_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  typedef struct {
    logic [31:0] result;
    logic [3:0]  nf;
    logic [3:0]  op;
    logic [3:0]  cond;
    logic        s;
    logic [3:0]  rd;
  } bundle_t;

  typedef struct {
    logic        valid;
    logic        stall;
    bundle_t     b;
    logic        expReady;
    logic        expPending;
    logic        expWbEn;
    logic [3:0]  expAddr;
    logic [31:0] expData;
    logic        expCommit;
    logic        expSquash;
    logic [3:0]  expFlag;
  } vec_t;

  int total = 0;
  int bad   = 0;

  bundle_t     modelQ[$];
  logic [3:0]  mFlag;
  logic        mWbEn, mCommit, mSquash;
  logic [3:0]  mAddr;
  logic [31:0] mData;

  logic sampledReady, sampledPending, accepted;

  // Conditions come in complementary pairs: the low cond bit inverts the base test.
  function automatic logic condHolds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic updatesFlags(input logic [3:0] op, input logic s);
    if (op == 4'hB) return 1'b1;
    if (op == 4'h6 || op == 4'h7 || op >= 4'hC) return 1'b0;
    return s;
  endfunction

  function automatic bundle_t mkB(input logic [31:0] result, input logic [3:0] nf,
                                  input logic [3:0] op, input logic [3:0] cond,
                                  input logic s, input logic [3:0] rd);
    bundle_t b;
    b.result = result; b.nf = nf; b.op = op; b.cond = cond; b.s = s; b.rd = rd;
    return b;
  endfunction

  function automatic vec_t mkVec(input logic valid, input bundle_t b,
                                 input logic r, input logic p, input logic w,
                                 input logic [3:0] a, input logic [31:0] d,
                                 input logic c, input logic sq, input logic [3:0] f);
    vec_t v;
    v.valid = valid; v.stall = 1'b0; v.b = b;
    v.expReady = r; v.expPending = p; v.expWbEn = w; v.expAddr = a;
    v.expData = d; v.expCommit = c; v.expSquash = sq; v.expFlag = f;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    mFlag = 4'b0000; mWbEn = 1'b0; mAddr = '0; mData = '0;
    mCommit = 1'b0; mSquash = 1'b0;
  endtask

  // One clock: drive at negedge, check ready/pending, step model on posedge, check registered outputs.
  task automatic applyStimulus(input logic valid, input logic stall, input bundle_t b);
    bundle_t h;
    logic pass, expReady, expPending;
    @(negedge clk);
    io.in_valid = valid; io.in_result = b.result; io.in_new_flag = b.nf;
    io.in_opcode = b.op; io.in_cond = b.cond; io.in_s = b.s; io.in_rd = b.rd;
    io.wb_stall = stall;
    #1;
    expReady = (modelQ.size() < DEPTH);
    expPending = 1'b0;
    foreach (modelQ[i]) if (updatesFlags(modelQ[i].op, modelQ[i].s)) expPending = 1'b1;
    sampledReady   = io.in_ready;
    sampledPending = io.flags_pending;
    checkOutput("model in_ready", 32'(io.in_ready), 32'(expReady));
    checkOutput("model flags_pending", 32'(io.flags_pending), 32'(expPending));
    accepted = valid && expReady;
    @(posedge clk);
    mWbEn = 1'b0; mCommit = 1'b0; mSquash = 1'b0;
    if (modelQ.size() > 0 && !stall) begin
      h = modelQ.pop_front();
      pass = condHolds(h.cond, mFlag);
      if (pass && h.op <= 4'hA) begin
        mWbEn = 1'b1; mAddr = h.rd; mData = h.result;
      end
      mCommit = pass && (h.op < 4'hC);
      mSquash = !mCommit;
      if (pass && updatesFlags(h.op, h.s)) mFlag = h.nf;
    end
    if (accepted) modelQ.push_back(b);
    #1;
    checkOutput("model wb_en", 32'(io.wb_en), 32'(mWbEn));
    checkOutput("model wb_addr", 32'(io.wb_addr), 32'(mAddr));
    checkOutput("model wb_data", io.wb_data, mData);
    checkOutput("model commit_pulse", 32'(io.commit_pulse), 32'(mCommit));
    checkOutput("model squash_pulse", 32'(io.squash_pulse), 32'(mSquash));
    checkOutput("model flag_out", 32'(io.flag_out), 32'(mFlag));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " wb_en"}, 32'(io.wb_en), 32'(0));
    checkOutput({tag, " wb_addr"}, 32'(io.wb_addr), 32'(0));
    checkOutput({tag, " wb_data"}, io.wb_data, 32'(0));
    checkOutput({tag, " commit_pulse"}, 32'(io.commit_pulse), 32'(0));
    checkOutput({tag, " squash_pulse"}, 32'(io.squash_pulse), 32'(0));
    checkOutput({tag, " flag_out"}, 32'(io.flag_out), 32'(0));
    checkOutput({tag, " in_ready"}, 32'(io.in_ready), 32'(1));
    checkOutput({tag, " flags_pending"}, 32'(io.flags_pending), 32'(0));
  endtask

  vec_t    tbl[10];
  bundle_t idle;

  initial begin
    idle = mkB(32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
    // ADD, CMP sets Z, SUB on EQ, NE squashed, MOV with S, then ADD setting N.
    tbl[0] = mkVec(1'b1, mkB(32'h5,  4'b0000, 4'h0, 4'hE, 1'b1, 4'd3), 1, 0, 0, 4'd0, 32'h0,  0, 0, 4'b0000);
    tbl[1] = mkVec(1'b1, mkB(32'h0,  4'b0100, 4'hB, 4'hE, 1'b0, 4'd0), 1, 1, 1, 4'd3, 32'h5,  1, 0, 4'b0000);
    tbl[2] = mkVec(1'b1, mkB(32'h7,  4'b0000, 4'h1, 4'h0, 1'b0, 4'd2), 1, 1, 0, 4'd3, 32'h5,  1, 0, 4'b0100);
    tbl[3] = mkVec(1'b1, mkB(32'h9,  4'b0000, 4'h0, 4'h1, 1'b0, 4'd5), 1, 0, 1, 4'd2, 32'h7,  1, 0, 4'b0100);
    tbl[4] = mkVec(1'b0, idle,                                          1, 0, 0, 4'd2, 32'h7,  0, 1, 4'b0100);
    tbl[5] = mkVec(1'b1, mkB(32'hAB, 4'b1111, 4'h7, 4'hE, 1'b1, 4'd4), 1, 0, 0, 4'd2, 32'h7,  0, 0, 4'b0100);
    tbl[6] = mkVec(1'b0, idle,                                          1, 0, 1, 4'd4, 32'hAB, 1, 0, 4'b0100);
    tbl[7] = mkVec(1'b1, mkB(32'h11, 4'b1000, 4'h0, 4'hE, 1'b1, 4'd1), 1, 0, 0, 4'd4, 32'hAB, 0, 0, 4'b0100);
    tbl[8] = mkVec(1'b0, idle,                                          1, 1, 1, 4'd1, 32'h11, 1, 0, 4'b1000);
    tbl[9] = mkVec(1'b0, idle,                                          1, 0, 0, 4'd1, 32'h11, 0, 0, 4'b1000);

    io.in_valid = 1'b0; io.in_result = '0; io.in_new_flag = '0; io.in_opcode = '0;
    io.in_cond = '0; io.in_s = 1'b0; io.in_rd = '0; io.wb_stall = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].valid, tbl[i].stall, tbl[i].b);
      checkOutput($sformatf("vec%0d in_ready", i), 32'(sampledReady), 32'(tbl[i].expReady));
      checkOutput($sformatf("vec%0d flags_pending", i), 32'(sampledPending), 32'(tbl[i].expPending));
      checkOutput($sformatf("vec%0d wb_en", i), 32'(io.wb_en), 32'(tbl[i].expWbEn));
      checkOutput($sformatf("vec%0d wb_addr", i), 32'(io.wb_addr), 32'(tbl[i].expAddr));
      checkOutput($sformatf("vec%0d wb_data", i), io.wb_data, tbl[i].expData);
      checkOutput($sformatf("vec%0d commit", i), 32'(io.commit_pulse), 32'(tbl[i].expCommit));
      checkOutput($sformatf("vec%0d squash", i), 32'(io.squash_pulse), 32'(tbl[i].expSquash));
      checkOutput($sformatf("vec%0d flag_out", i), 32'(io.flag_out), 32'(tbl[i].expFlag));
    end

    // Stall fills the buffer, third bundle is held upstream, then drains in order.
    applyStimulus(1'b1, 1'b1, mkB(32'h100, 4'h0, 4'h0, 4'hE, 1'b0, 4'd6));
    applyStimulus(1'b1, 1'b1, mkB(32'h200, 4'h0, 4'h0, 4'hE, 1'b0, 4'd7));
    applyStimulus(1'b1, 1'b1, mkB(32'h300, 4'h0, 4'h0, 4'hE, 1'b0, 4'd8));
    checkOutput("stall third held", 32'(sampledReady), 32'(0));
    applyStimulus(1'b1, 1'b0, mkB(32'h300, 4'h0, 4'h0, 4'hE, 1'b0, 4'd8));
    checkOutput("drain first addr", 32'(io.wb_addr), 32'(6));
    applyStimulus(1'b1, 1'b0, mkB(32'h300, 4'h0, 4'h0, 4'hE, 1'b0, 4'd8));
    checkOutput("drain second data", io.wb_data, 32'h200);
    applyStimulus(1'b0, 1'b0, idle);
    checkOutput("drain third data", io.wb_data, 32'h300);
    checkOutput("drain third wb_en", 32'(io.wb_en), 32'(1));

    // Fill to full, then stream for 10 cycles with push and pop overlapping.
    applyStimulus(1'b1, 1'b1, mkB(32'h1000, 4'h0, 4'h2, 4'hE, 1'b0, 4'd1));
    applyStimulus(1'b1, 1'b1, mkB(32'h1001, 4'h0, 4'h2, 4'hE, 1'b0, 4'd2));
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0, mkB(32'h2000 + 32'(k), 4'h0, 4'h3, 4'hE, 1'b0, 4'(k)));
    end
    repeat (3) applyStimulus(1'b0, 1'b0, idle);

    // Reset with two entries buffered must discard them without a write.
    applyStimulus(1'b1, 1'b1, mkB(32'hDEAD, 4'hF, 4'h0, 4'hE, 1'b1, 4'd9));
    applyStimulus(1'b1, 1'b1, mkB(32'hBEEF, 4'hF, 4'h0, 4'hE, 1'b1, 4'd10));
    checkOutput("pre-reset full", 32'(io.in_ready), 32'(0));
    @(negedge clk);
    io.in_valid = 1'b0;
    io.wb_stall = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, mkB(32'h55, 4'hF, 4'hE, 4'hE, 1'b1, 4'd9));
    checkOutput("post-reset no write", 32'(io.wb_en), 32'(0));
    applyStimulus(1'b0, 1'b0, idle);
    checkOutput("opE squash", 32'(io.squash_pulse), 32'(1));
    checkOutput("opE no commit", 32'(io.commit_pulse), 32'(0));
    checkOutput("opE no write", 32'(io.wb_en), 32'(0));
    checkOutput("opE flags kept", 32'(io.flag_out), 32'(0));

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                    mkB($urandom, 4'($urandom), 4'($urandom), 4'($urandom),
                        1'($urandom), 4'($urandom)));
    end
    repeat (4) applyStimulus(1'b0, 1'b0, idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
